// File: rtl/div_unit_pkg.sv
// Shared word-width constants and divider FSM encodings.
package div_unit_pkg;

  localparam int WORD_BUS = 32;
  localparam logic [WORD_BUS-1:0] ZERO_WORD = '0;
  localparam int DIV_STEPS = 32;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_RUN  = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; emits one HI (remainder) / LO (quotient) write.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = WORD_BUS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             o_we,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] neg;
    neg = -x;
    return (is_signed && (x < 0)) ? $unsigned(neg) : $unsigned(x);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic negate);
    logic signed [WIDTH-1:0] s;
    s = $signed(mag);
    return negate ? $unsigned(-s) : mag;
  endfunction

  div_state_e       state;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_raw;
  logic             sgn_op;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             neg_q;
  logic             neg_r;
  logic             accept;

  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  assign accept = (state == DIV_IDLE) && start && !cancel;

  // One restoring step: 33-bit partial remainder compared against the divisor.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    take     = (shifted >= {1'b0, dvs});
    rem_next = take ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], take};
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_raw  <= dividend;
      b_raw  <= divisor;
      sgn_op <= signed_op;
    end
    case (state)
      DIV_PREP: begin
        quo   <= magnitude(a_raw, sgn_op);
        dvs   <= magnitude(b_raw, sgn_op);
        rem   <= '0;
        neg_q <= sgn_op & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
        neg_r <= sgn_op & a_raw[WIDTH-1];
      end
      DIV_RUN: begin
        rem <= rem_next;
        quo <= quo_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      o_we  <= 1'b0;
      o_hi  <= '0;
      o_lo  <= '0;
    end else begin
      o_we <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start && !cancel) begin
            state <= DIV_PREP;
            busy  <= 1'b1;
          end
        end
        DIV_PREP: begin
          if (cancel) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end else if (b_raw == ZERO_WORD) begin
            state <= DIV_DONE;
            busy  <= 1'b0;
            o_we  <= 1'b1;
            o_hi  <= a_raw;
            o_lo  <= '1;
          end else begin
            state <= DIV_RUN;
            cnt   <= '0;
          end
        end
        DIV_RUN: begin
          if (cancel) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
            if (cnt == LAST_STEP) state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          if (cancel) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DIV_DONE;
            busy  <= 1'b0;
            o_we  <= 1'b1;
            o_hi  <= apply_sign(rem, neg_r);
            o_lo  <= apply_sign(quo, neg_q);
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divides, divide-by-zero, cancel, reset, ignored starts.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        o_we;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .cancel    (cancel),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .o_we      (o_we),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_we: o_we=1 at cycle %0d, expected 0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", o_hi, e.hi);
        chk("lo", o_lo, e.lo);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Called just after a rising edge; asserts start in the current cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input bit dz, input bit pulse_busy);
    int   c;
    bit   done;
    exp_t e;
    done      = 1'b0;
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    c         = cyc;
    e.hi      = ehi;
    e.lo      = elo;
    e.cyc     = c + (dz ? 2 : 35);
    sb.push_back(e);
    @(posedge clk); #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    signed_op = ~s;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      chk("busy_while_div", {31'd0, busy}, 32'd1);
      start = pulse_busy && (i == 4 || i == 20);
      if (start) begin
        dividend = 32'd7;
        divisor  = 32'd1;
      end
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout: no o_we within 60 cycles of start at cycle %0d", c);
      sb.delete();
    end
    start = pulse_busy;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_hi", o_hi, ehi);
    chk("hold_lo", o_lo, elo);
    if (pulse_busy) begin
      @(negedge clk); #1;
      chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int c;
    rst       = 1'b1;
    start     = 1'b0;
    cancel    = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we", {31'd0, o_we}, 32'd0);
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_lo", o_lo, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue(32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 1'b0);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'h10, 1'b0, 32'hF, 32'h0FFF_FFFF, 1'b0, 1'b0);
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFE, 32'd14, 1'b0, 1'b0);
    issue(32'h1234, 32'd0, 1'b0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(32'd50, 32'd5, 1'b0, 32'd0, 32'd10, 1'b0, 1'b1);

    // cancel in IDLE blocks acceptance
    start  = 1'b1;
    cancel = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    cancel = 1'b0;
    @(negedge clk); #1;
    chk("cancel_idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // cancel during RUN
    dividend  = 32'd1000;
    divisor   = 32'd3;
    signed_op = 1'b0;
    start     = 1'b1;
    c         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk); #1;
    chk("busy_before_cancel", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    cancel = 1'b0;
    @(negedge clk); #1;
    chk("busy_after_cancel", {31'd0, busy}, 32'd0);
    while (cyc < c + 41) begin
      @(negedge clk); #1;
      chk("we_after_cancel", {31'd0, o_we}, 32'd0);
    end
    @(posedge clk); #1;
    issue(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0, 1'b0);

    // reset mid-divide clears outputs and drops the write
    dividend  = 32'h5555_5555;
    divisor   = 32'd5;
    signed_op = 1'b0;
    start     = 1'b1;
    c         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_cycle", cyc, c + 21);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_we", {31'd0, o_we}, 32'd0);
    chk("midrst_hi", o_hi, 32'd0);
    chk("midrst_lo", o_lo, 32'd0);
    repeat (30) begin
      @(negedge clk); #1;
      chk("we_after_rst", {31'd0, o_we}, 32'd0);
    end

    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL leftover: %0d writes outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
